inverter_arbiter: RTL
=====================

# inverter_arbiter

Round-robin arbiter and sequencer that shares one `inverter` IP core (b = ~a, 32-bit) among NUM_REQ requesters. Each requester presents an operand with valid/ready. The arbiter grants one requester, registers the operand into the shared core, captures the inverted result, and returns it to the granted requester with a per-requester response handshake. It sits between the ip_cores `inverter` and the scheduled datapath ports that need bitwise inversion.

## Interface
- NUM_REQ, 4: number of requesters, 2..16
- WIDTH, 32: operand/result width; must match the `inverter` core
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_REQ  per-requester operand valid
- req_data  in  NUM_REQ*WIDTH  packed operands; requester i occupies bits [i*WIDTH +: WIDTH]
- req_ready  out  NUM_REQ  one-hot (or zero) accept for the granted requester
- resp_valid  out  NUM_REQ  one-hot result valid, addressed to the owner
- resp_data  out  WIDTH  result, shared across requesters
- resp_ready  in  NUM_REQ  per-requester result accept
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - Compute the grant from req_valid.
  - Round-robin: search starts at pointer `rr_ptr` and wraps modulo NUM_REQ.
  - req_ready[g]=1 combinationally for the winner g only; all other bits are 0.
  - No valid request: req_ready=0 and the FSM stays in IDLE.
- Acceptance (req_valid[g] & req_ready[g]):
  - Latch req_data slice g into `op_q` and g into `owner_q`.
  - rr_ptr <= (g+1) mod NUM_REQ.
  - Next state is ISSUE.
- ISSUE: the `inverter` instance drives ~op_q; latch it into `res_q` and go to RESP. req_ready=0.
- RESP:
  - resp_valid[owner_q]=1 and resp_data=res_q.
  - Both hold stable until resp_ready[owner_q]=1.
  - resp_ready bits of non-owners are ignored.
  - On the handshake, go to IDLE.
- rr_ptr advances only on acceptance, never on idle cycles.
- A requester dropping req_valid before grant is legal. Once accepted, the operand is not re-sampled.
- Simultaneous requests: exactly one is granted per acceptance. The others wait with valid held.

## Timing
- Reset values:
  - state=IDLE, rr_ptr=0, op_q=0, res_q=0, owner_q=0.
  - resp_valid=0, resp_data=0, busy=0.
  - req_ready=0 while rst is high.
- Latency: acceptance in cycle T gives ISSUE at T+1 and resp_valid at T+2 (earliest).
- Throughput: one operation per 3 cycles when resp_ready is already high. The next acceptance is possible at T+3.
- Back-pressure: each cycle resp_ready[owner_q]=0 extends RESP by one cycle. Outputs stay unchanged during the stall.
- Reset mid-operation (ISSUE or RESP): the transaction is discarded and no response is issued. All registers return to their reset values immediately (asynchronous).
- req_ready depends combinationally on req_valid. Requesters must not make req_valid depend on req_ready.

## Configuration
- Macro: INVERTER_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest valid index always wins, and rr_ptr is not implemented (tied to 0).
- Undefined (default): round-robin as described above.

## Structure
- Package `inverter_arb_pkg` holds:
  - the state encoding (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2);
  - the default WIDTH=32;
  - the grant-search function (rotate, find first, rotate back).
- Sub-module: instantiate the existing `inverter` once (a=op_q, b feeds res_q). No other sub-modules.

## Test plan
- Single request: req_valid=4'b0001, data 32'h0000_0000. Required: resp_valid=4'b0001 two cycles after acceptance, resp_data=32'hFFFF_FFFF.
- All four valid from reset (data 32'h1, 32'h2, 32'h3, 32'h4, resp_ready all 1). Required:
  - grants in order 0,1,2,3;
  - responses 32'hFFFF_FFFE, FFFF_FFFD, FFFF_FFFC, FFFF_FFFB;
  - 3-cycle spacing.
- Back-pressure: requester 2 sends 32'hA5A5_A5A5 and holds resp_ready[2]=0 for 5 cycles. Required:
  - resp_data is held at 32'h5A5A_5A5A throughout;
  - busy=1 throughout;
  - no other req_ready is asserted;
  - release completes the transfer, and IDLE follows.
- Fairness: requesters 0 and 3 valid continuously. Required: grants alternate 0,3,0,3. With INVERTER_ARB_FIXED_PRIO_EN: always 0.
- Reset in RESP: assert rst while resp_valid=4'b0100. Required: resp_valid=0 and busy=0 immediately; after release, a pending request at index 1 is granted first (rr_ptr=0 search).

Source files
------------

// File: rtl/inverter_arb_pkg.sv
// Shared types and the grant-search helper for inverter_arbiter.
// Grant search: rotate the request vector by the pointer, find the first set bit, rotate back.
package inverter_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 32;
  localparam int MAX_REQ       = 16;
  localparam int IDX_W         = 4;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } grant_t;

  function automatic grant_t rr_grant(input logic [MAX_REQ-1:0] valid,
                                      input logic [IDX_W-1:0]   ptr,
                                      input int                 n);
    logic [2*MAX_REQ-1:0] dbl;
    logic [2*MAX_REQ-1:0] rot;
    grant_t               g;
    int                   s;
    dbl = {{MAX_REQ{1'b0}}, valid} | ({{MAX_REQ{1'b0}}, valid} << n);
    rot = dbl >> ptr;
    g   = '0;
    // Scan downwards so the lowest rotated position wins.
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (i < n && rot[i]) begin
        s = i + int'(ptr);
        if (s >= n) s = s - n;
        g.found = 1'b1;
        g.idx   = IDX_W'(s);
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/inverter.sv
// Shared bitwise-inversion IP core (b = ~a).
module inverter #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b
);
  assign b = ~a;
endmodule

// File: rtl/inverter_arbiter.sv
// Round-robin arbiter/sequencer sharing one inverter core among NUM_REQ requesters.
// Build option: define INVERTER_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module inverter_arbiter
  import inverter_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = DEFAULT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]         resp_data,
  input  logic [NUM_REQ-1:0]       resp_ready,
  output logic                     busy
);

  state_t             r_state;
  state_t             w_state_next;
  logic [IDX_W-1:0]   r_owner_q;
  logic [WIDTH-1:0]   r_op_q;
  logic [WIDTH-1:0]   r_res_q;
  logic [WIDTH-1:0]   w_inv;
  logic [WIDTH-1:0]   w_sel_data;
  logic [WIDTH-1:0]   w_masked [NUM_REQ];
  logic [MAX_REQ-1:0] w_valid_ext;
  logic [NUM_REQ-1:0] w_grant_oh;
  logic [NUM_REQ-1:0] w_owner_oh;
  logic [IDX_W-1:0]   w_ptr_search;
  grant_t             w_grant;
  logic               w_accept;
  logic               w_resp_done;

  genvar gi;
  generate
    for (gi = 0; gi < MAX_REQ; gi++) begin : g_valid_ext
      if (gi < NUM_REQ) begin : g_used
        assign w_valid_ext[gi] = req_valid[gi];
      end else begin : g_pad
        assign w_valid_ext[gi] = 1'b0;
      end
    end
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign w_grant_oh[gi] = w_grant.found && (w_grant.idx == IDX_W'(gi));
      assign w_owner_oh[gi] = (r_owner_q == IDX_W'(gi));
      assign w_masked[gi]   = req_data[gi*WIDTH +: WIDTH] & {WIDTH{w_grant_oh[gi]}};
    end
  endgenerate

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) w_sel_data = w_sel_data | w_masked[i];
  end

`ifdef INVERTER_ARB_FIXED_PRIO_EN
  assign w_ptr_search = '0;
`else
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] w_ptr_next;

  assign w_ptr_search = r_rr_ptr;
  assign w_ptr_next   = (w_grant.idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_grant.idx + IDX_W'(1);

  // Pointer moves only on acceptance so idle cycles never skip a requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_rr_ptr <= '0;
    else if (w_accept) r_rr_ptr <= w_ptr_next;
  end
`endif

  assign w_grant     = rr_grant(w_valid_ext, w_ptr_search, NUM_REQ);
  assign w_resp_done = |(resp_ready & w_owner_oh);

  inverter #(.WIDTH(WIDTH)) u_inverter (
    .a (r_op_q),
    .b (w_inv)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    req_ready    = '0;
    resp_valid   = '0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (!rst && w_grant.found) begin
          req_ready    = w_grant_oh;
          w_accept     = 1'b1;
          w_state_next = ISSUE;
        end
      end
      ISSUE: w_state_next = RESP;
      RESP: begin
        resp_valid = w_owner_oh;
        if (w_resp_done) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_q    <= '0;
      r_owner_q <= '0;
      r_res_q   <= '0;
    end else begin
      if (w_accept) begin
        r_op_q    <= w_sel_data;
        r_owner_q <= w_grant.idx;
      end
      if (r_state == ISSUE) r_res_q <= w_inv;
    end
  end

  assign resp_data = r_res_q;
  assign busy      = (r_state != IDLE);

endmodule
